lut_lookup: RTL and testbench

Table-lookup engine that reads the LUTs written during LUT generation. It takes one 128-bit state word and splits it into lanes: 16 × 8-bit lanes in byte mode, 8 × 16-bit lanes in 16-bit mode. For each lane it issues one read to the LUT memory, extracts that lane's element from the returned 128-bit row, and assembles the 128-bit result. It sits between the table RAM and the white-box round datapath.

---
 rtl/lut_lookup_if.sv | 24 ++
 rtl/lut_lookup.sv | 134 +++++++++++++
 tb/tb_lut_lookup.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_lookup_if.sv
// Handshake and LUT memory bus for the lut_lookup engine.
// The slave side is the lookup engine; the master side is the
// requester together with the table RAM.
interface lut_lookup_if;
    logic [2:0]   alg_mode;
    logic         start;
    logic [127:0] x_in;
    logic         busy;
    logic         mem_rd;
    logic [12:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [127:0] y_out;
    logic         done;

    modport master (
        output alg_mode, start, x_in, mem_rdata,
        input  busy, mem_rd, mem_addr, y_out, done
    );

    modport slave (
        input  alg_mode, start, x_in, mem_rdata,
        output busy, mem_rd, mem_addr, y_out, done
    );
endinterface

// File: rtl/lut_lookup.sv
// Table-lookup engine: splits a 128-bit word into 16 byte lanes or
// 8 halfword lanes, issues one LUT row read per lane, slices each
// returned row with the element index of the lane that issued it and
// assembles the 128-bit result.
module lut_lookup (
    input  logic        clk,
    input  logic        rst,
    lut_lookup_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    lane_q, lane_d;     // lane being issued this cycle
    logic [127:0]  x_q, x_d;           // latched request word
    logic          mode16_q, mode16_d; // 1 = 16-bit lanes
    logic          rd_q, rd_d;         // a read was issued last cycle
    logic [3:0]    k_q, k_d;           // element index of that read
    logic [3:0]    plane_q, plane_d;   // lane number of that read
    logic [127:0]  acc_q, acc_d;       // partially assembled result
    logic [127:0]  y_q, y_d;           // result register

    logic [7:0]    v8;
    logic [15:0]   v16;
    logic [12:0]   addr_cur;
    logic [3:0]    k_cur;
    logic          last_lane;

    // Select the current lane value and split it into row address and element index.
    // Lane i sits at bit 127-W*i downward; 127-8*i == {~i,3'b111}, 127-16*i == {~i,4'b1111}.
    always_comb begin
        v8  = x_q[{~lane_q, 3'b111} -: 8];
        v16 = x_q[{~lane_q[2:0], 4'b1111} -: 16];
        if (mode16_q) begin
            addr_cur  = v16[15:3];
            k_cur     = {1'b0, v16[2:0]};
            last_lane = (lane_q[2:0] == 3'd7);
        end else begin
            addr_cur  = {9'b0, v8[7:4]};
            k_cur     = v8[3:0];
            last_lane = (lane_q == 4'd15);
        end
    end

    // Next-state, datapath capture and bus outputs.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        x_d          = x_q;
        mode16_d     = mode16_q;
        rd_d         = 1'b0;
        k_d          = k_q;
        plane_d      = plane_q;
        acc_d        = acc_q;
        y_d          = y_q;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = 13'd0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != S_IDLE);

        // Row data is only meaningful in the cycle after a read; slice it
        // with the element index that travelled alongside that read.
        if (rd_q) begin
            if (mode16_q) begin
                acc_d[{~plane_q[2:0], 4'b1111} -: 16] = bus.mem_rdata[{~k_q[2:0], 4'b1111} -: 16];
            end else begin
                acc_d[{~plane_q, 3'b111} -: 8] = bus.mem_rdata[{~k_q, 3'b111} -: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_ISSUE;
                    x_d      = bus.x_in;
                    mode16_d = (bus.alg_mode != 3'b000);
                    lane_d   = 4'd0;
                    acc_d    = '0;
                end
            end
            S_ISSUE: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = addr_cur;
                rd_d         = 1'b1;
                k_d          = k_cur;
                plane_d      = lane_q;
                lane_d       = lane_q + 4'd1;
                if (last_lane) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last lane lands in acc_d above; publish the whole word at once.
                y_d     = acc_d;
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.y_out = y_q;

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= 4'd0;
            x_q      <= '0;
            mode16_q <= 1'b0;
            rd_q     <= 1'b0;
            k_q      <= 4'd0;
            plane_q  <= 4'd0;
            acc_q    <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            x_q      <= x_d;
            mode16_q <= mode16_d;
            rd_q     <= rd_d;
            k_q      <= k_d;
            plane_q  <= plane_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: tb/tb_lut_lookup.sv
// Directed testbench for lut_lookup with a behavioural LUT memory.
module tb_lut_lookup;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   pat;   // 0: byte identity, 1: 16-bit identity, 2: byte v^0x5A

    lut_lookup_if bus ();

    lut_lookup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generated LUT row contents for row a.
    function automatic logic [127:0] row_of(input int p, input logic [12:0] a);
        logic [127:0] r;
        int base;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (p == 1) begin
                base = 8 * int'(a) + k;
                if (k < 8) r[127 - 16*k -: 16] = base[15:0];
            end else begin
                base = 16 * int'(a) + k;
                r[127 - 8*k -: 8] = base[7:0] ^ ((p == 2) ? 8'h5A : 8'h00);
            end
        end
        return r;
    endfunction

    // LUT memory: row valid one cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= row_of(pat, bus.mem_addr);
        else            bus.mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] mode, input logic [127:0] x);
        bus.alg_mode = mode;
        bus.x_in     = x;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 13'd0 ||
            bus.done !== 1'b0 || bus.y_out !== 128'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b rd=%b addr=%h done=%b y=%h, want all zero",
                     bus.busy, bus.mem_rd, bus.mem_addr, bus.done, bus.y_out);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_identity();
        logic [127:0] x;
        x   = 128'h00112233445566778899AABBCCDDEEFF;
        pat = 0;
        issue(3'b000, x);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 13'(i) || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL byte_addr lane %0d: rd=%b addr=%h busy=%b, want rd=1 addr=%h busy=1",
                         i, bus.mem_rd, bus.mem_addr, bus.busy, 13'(i));
            end
            tick();
        end
        n_vec++;
        if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 13'd0 || bus.done !== 1'b0 ||
            bus.busy !== 1'b1 || bus.y_out !== 128'd0) begin
            n_err++;
            $display("FAIL byte_drain: rd=%b addr=%h done=%b busy=%b y=%h, want 0 0 0 1 0",
                     bus.mem_rd, bus.mem_addr, bus.done, bus.busy, bus.y_out);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b1 || bus.y_out !== x) begin
            n_err++;
            $display("FAIL byte_done_c18: done=%b y=%h, want done=1 y=%h", bus.done, bus.y_out, x);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.y_out !== x) begin
            n_err++;
            $display("FAIL byte_after: done=%b busy=%b y=%h, want 0 0 %h", bus.done, bus.busy, bus.y_out, x);
        end
    endtask

    task automatic test_word_identity();
        logic [127:0] x;
        logic [12:0]  ea [8];
        ea  = '{13'h0000, 13'h0000, 13'h0001, 13'h03FF, 13'h1FFF, 13'h1000, 13'h0246, 13'h1579};
        x   = 128'h0000_0007_0008_1FFF_FFFF_8000_1234_ABCD;
        pat = 1;
        issue(3'b010, x);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== ea[i]) begin
                n_err++;
                $display("FAIL word_addr lane %0d: rd=%b addr=%h, want rd=1 addr=%h",
                         i, bus.mem_rd, bus.mem_addr, ea[i]);
            end
            tick();
        end
        n_vec++;
        if (bus.mem_rd !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL word_drain: rd=%b done=%b, want 0 0", bus.mem_rd, bus.done);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b1 || bus.y_out !== x) begin
            n_err++;
            $display("FAIL word_done_c10: done=%b y=%h, want done=1 y=%h", bus.done, bus.y_out, x);
        end
        tick();
    endtask

    task automatic test_nonidentity();
        int cyc;
        pat = 2;
        issue(3'b000, 128'd0);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (bus.done !== 1'b1 || cyc !== 18 || bus.y_out !== {16{8'h5A}}) begin
            n_err++;
            $display("FAIL xor_table: done=%b cycle=%0d y=%h, want done at 18 y=%h",
                     bus.done, cyc, bus.y_out, {16{8'h5A}});
        end
        tick();
    endtask

    task automatic test_ignored_inputs();
        logic [127:0] x;
        int n_done;
        int done_cyc;
        x        = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        pat      = 0;
        n_done   = 0;
        done_cyc = -1;
        issue(3'b000, x);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) bus.alg_mode = 3'b001;
            if (cyc == 5) begin
                bus.start = 1'b1;
                bus.x_in  = {128{1'b1}};
            end
            if (cyc == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                n_vec++;
                if (bus.y_out !== x) begin
                    n_err++;
                    $display("FAIL ignored_result: y=%h, want %h", bus.y_out, x);
                end
            end
            tick();
        end
        n_vec++;
        if (n_done !== 1 || done_cyc !== 18) begin
            n_err++;
            $display("FAIL ignored_done: count=%0d cycle=%0d, want count=1 cycle=18", n_done, done_cyc);
        end
        bus.alg_mode = 3'b000;
    endtask

    task automatic test_reset_mid();
        logic [127:0] x2;
        int n_done;
        int cyc;
        pat = 0;
        issue(3'b000, 128'h00112233445566778899AABBCCDDEEFF);
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (bus.mem_addr !== 13'd5) begin
            n_err++;
            $display("FAIL rstmid_lane5: addr=%h, want 0005", bus.mem_addr);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 13'd0 ||
            bus.done !== 1'b0 || bus.y_out !== 128'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs: busy=%b rd=%b addr=%h done=%b y=%h, want all zero",
                     bus.busy, bus.mem_rd, bus.mem_addr, bus.done, bus.y_out);
        end
        tick();
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        n_vec++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL rstmid_no_done: done pulses=%0d, want 0", n_done);
        end
        x2  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pat = 1;
        issue(3'b111, x2);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (bus.done !== 1'b1 || cyc !== 10 || bus.y_out !== x2) begin
            n_err++;
            $display("FAIL rstmid_restart: done=%b cycle=%0d y=%h, want done at 10 y=%h",
                     bus.done, cyc, bus.y_out, x2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] xa;
        logic [127:0] xb;
        int cyc;
        xa  = 128'hFFEEDDCCBBAA99887766554433221100;
        xb  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        pat = 0;
        issue(3'b000, xa);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (bus.done !== 1'b1 || bus.y_out !== xa) begin
            n_err++;
            $display("FAIL b2b_first: done=%b y=%h, want done=1 y=%h", bus.done, bus.y_out, xa);
        end
        // Hold start high through the DONE cycle and the following one.
        pat          = 1;
        bus.alg_mode = 3'b100;
        bus.x_in     = xb;
        bus.start    = 1'b1;
        tick();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_start: busy=%b done=%b, want busy=0 done=0", bus.busy, bus.done);
        end
        tick();
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.mem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b rd=%b, want 1 1", bus.busy, bus.mem_rd);
        end
        for (int c = 1; c <= 9; c++) begin
            n_vec++;
            if (bus.y_out !== xa || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_hold cycle %0d: y=%h done=%b, want y=%h done=0", c, bus.y_out, bus.done, xa);
            end
            tick();
        end
        n_vec++;
        if (bus.done !== 1'b1 || bus.y_out !== xb) begin
            n_err++;
            $display("FAIL b2b_second: done=%b y=%h, want done=1 y=%h", bus.done, bus.y_out, xb);
        end
        tick();
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        pat           = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.alg_mode  = 3'b000;
        bus.x_in      = '0;
        bus.mem_rdata = '0;
        #1;
        test_reset();
        test_byte_identity();
        test_word_identity();
        test_nonidentity();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
